// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - age-ordered collapsing reservation station with completion snoop
// Slot 0 holds the oldest op; the lowest-index ready entry is offered to the functional unit.
module reservation_station #(
  parameter int DEPTH      = 4,
  parameter int ROBsizeLog = 6,
  parameter int CMDW       = 10
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic                         writeEn_i,
  input  logic [ROBsizeLog-1:0]        robTag_i,
  input  logic [ROBsizeLog-1:0]        tag1_i,
  input  logic [ROBsizeLog-1:0]        tag2_i,
  input  logic [64:0]                  val1_i,
  input  logic [64:0]                  val2_i,
  input  logic [CMDW-1:0]              commands_i,
  output logic                         stall_o,
  input  logic                         flush_i,
  input  logic [ROBsizeLog-1:0]        cdbTag_i,
  input  logic [64:0]                  cdbVal_i,
  output logic                         issueValid_o,
  input  logic                         issueReady_i,
  output logic [ROBsizeLog-1:0]        issueTag_o,
  output logic [63:0]                  issueVal1_o,
  output logic [63:0]                  issueVal2_o,
  output logic [CMDW-1:0]              issueCmd_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  logic [ROBsizeLog-1:0] rob_q [DEPTH];
  logic [ROBsizeLog-1:0] t1_q  [DEPTH];
  logic [ROBsizeLog-1:0] t2_q  [DEPTH];
  logic [63:0]           v1_q  [DEPTH];
  logic [63:0]           v2_q  [DEPTH];
  logic [CMDW-1:0]       cmd_q [DEPTH];
  logic [CW-1:0]         count_q;

  logic [ROBsizeLog-1:0] rob_n [DEPTH];
  logic [ROBsizeLog-1:0] t1_n  [DEPTH];
  logic [ROBsizeLog-1:0] t2_n  [DEPTH];
  logic [63:0]           v1_n  [DEPTH];
  logic [63:0]           v2_n  [DEPTH];
  logic [CMDW-1:0]       cmd_n [DEPTH];
  logic [CW-1:0]         count_n;

  logic [IW-1:0] sel;
  logic          found;
  logic          fire;
  logic          do_write;
  logic [CW-1:0] cnt_keep;
  logic          unused_bits;

  assign unused_bits = ^{val1_i[64], val2_i[64], cdbVal_i[64]};

  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!found && i < int'(count_q) && t1_q[i] == '0 && t2_q[i] == '0) begin
        found = 1'b1;
        sel   = IW'(i);
      end
    end
  end

  assign stall_o      = (count_q == CW'(DEPTH));
  assign count_o      = count_q;
  assign issueValid_o = found;
  assign issueTag_o   = found ? rob_q[sel] : '0;
  assign issueVal1_o  = found ? v1_q[sel]  : '0;
  assign issueVal2_o  = found ? v2_q[sel]  : '0;
  assign issueCmd_o   = found ? cmd_q[sel] : '0;

  assign fire     = found & issueReady_i;
  assign do_write = writeEn_i & ~stall_o;
  assign cnt_keep = count_q - CW'(fire);

  // Order matters: collapse past the issued slot, append at the new tail, then snoop everything
  // so a same-cycle write sees the broadcast too.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rob_n[i] = rob_q[i];
      t1_n[i]  = t1_q[i];
      t2_n[i]  = t2_q[i];
      v1_n[i]  = v1_q[i];
      v2_n[i]  = v2_q[i];
      cmd_n[i] = cmd_q[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (fire && i >= int'(sel)) begin
        rob_n[i] = rob_q[i+1];
        t1_n[i]  = t1_q[i+1];
        t2_n[i]  = t2_q[i+1];
        v1_n[i]  = v1_q[i+1];
        v2_n[i]  = v2_q[i+1];
        cmd_n[i] = cmd_q[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_write && i == int'(cnt_keep)) begin
        rob_n[i] = robTag_i;
        t1_n[i]  = tag1_i;
        t2_n[i]  = tag2_i;
        v1_n[i]  = val1_i[63:0];
        v2_n[i]  = val2_i[63:0];
        cmd_n[i] = commands_i;
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (cdbTag_i != '0 && t1_n[i] == cdbTag_i) begin
        t1_n[i] = '0;
        v1_n[i] = cdbVal_i[63:0];
      end
      if (cdbTag_i != '0 && t2_n[i] == cdbTag_i) begin
        t2_n[i] = '0;
        v2_n[i] = cdbVal_i[63:0];
      end
    end
    count_n = flush_i ? '0 : cnt_keep + CW'(do_write);
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= '0;
        t1_q[i]  <= '0;
        t2_q[i]  <= '0;
        v1_q[i]  <= '0;
        v2_q[i]  <= '0;
        cmd_q[i] <= '0;
      end
    end else begin
      count_q <= count_n;
      for (int i = 0; i < DEPTH; i++) begin
        rob_q[i] <= rob_n[i];
        t1_q[i]  <= t1_n[i];
        t2_q[i]  <= t2_n[i];
        v1_q[i]  <= v1_n[i];
        v2_q[i]  <= v2_n[i];
        cmd_q[i] <= cmd_n[i];
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station
// A queue-based reference model predicts each cycle's presentation and every accepted issue.
module tb_reservation_station;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        writeEn_i;
  logic [5:0]  robTag_i, tag1_i, tag2_i, cdbTag_i;
  logic [64:0] val1_i, val2_i, cdbVal_i;
  logic [9:0]  commands_i;
  logic        stall_o, flush_i, issueValid_o, issueReady_i;
  logic [5:0]  issueTag_o;
  logic [63:0] issueVal1_o, issueVal2_o;
  logic [9:0]  issueCmd_o;
  logic [2:0]  count_o;

  reservation_station dut (
    .clk_i(clk_i), .reset_i(reset_i), .writeEn_i(writeEn_i), .robTag_i(robTag_i),
    .tag1_i(tag1_i), .tag2_i(tag2_i), .val1_i(val1_i), .val2_i(val2_i),
    .commands_i(commands_i), .stall_o(stall_o), .flush_i(flush_i), .cdbTag_i(cdbTag_i),
    .cdbVal_i(cdbVal_i), .issueValid_o(issueValid_o), .issueReady_i(issueReady_i),
    .issueTag_o(issueTag_o), .issueVal1_o(issueVal1_o), .issueVal2_o(issueVal2_o),
    .issueCmd_o(issueCmd_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [5:0]  rob, t1, t2;
    logic [63:0] v1, v2;
    logic [9:0]  cmd;
  } ent_t;

  typedef struct {
    bit          valid;
    logic [5:0]  rob;
    logic [63:0] v1, v2;
    logic [9:0]  cmd;
    int          count;
    bit          stall;
  } st_t;

  ent_t mq[$];
  st_t  st_q[$];
  ent_t iss_q[$];
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Drives one cycle of stimulus, records what the model expects, then advances the model.
  task automatic step(input bit we, input logic [5:0] rob, input logic [5:0] t1, input logic [64:0] v1,
                      input logic [5:0] t2, input logic [64:0] v2, input logic [9:0] cmd,
                      input logic [5:0] ctag, input logic [64:0] cval, input bit rdy, input bit fl);
    st_t  st;
    ent_t e;
    int   s;
    bit   full;
    writeEn_i = we; robTag_i = rob; tag1_i = t1; val1_i = v1; tag2_i = t2; val2_i = v2;
    commands_i = cmd; cdbTag_i = ctag; cdbVal_i = cval; issueReady_i = rdy; flush_i = fl;
    s = -1;
    for (int i = 0; i < mq.size(); i++)
      if (s < 0 && mq[i].t1 == 0 && mq[i].t2 == 0) s = i;
    st.valid = (s >= 0);
    st.rob = 0; st.v1 = 0; st.v2 = 0; st.cmd = 0;
    if (s >= 0) begin
      st.rob = mq[s].rob; st.v1 = mq[s].v1; st.v2 = mq[s].v2; st.cmd = mq[s].cmd;
    end
    st.count = mq.size();
    st.stall = (mq.size() == 4);
    st_q.push_back(st);
    full = (mq.size() == 4);
    if (s >= 0 && rdy) begin
      iss_q.push_back(mq[s]);
      mq.delete(s);
    end
    if (we && !full) begin
      e.rob = rob; e.t1 = t1; e.t2 = t2; e.v1 = v1[63:0]; e.v2 = v2[63:0]; e.cmd = cmd;
      mq.push_back(e);
    end
    if (ctag != 0)
      for (int i = 0; i < mq.size(); i++) begin
        if (mq[i].t1 == ctag) begin mq[i].t1 = 0; mq[i].v1 = cval[63:0]; end
        if (mq[i].t2 == ctag) begin mq[i].t2 = 0; mq[i].v2 = cval[63:0]; end
      end
    if (fl) mq.delete();
    @(posedge clk_i);
    #2;
  endtask

  task automatic idle(input bit rdy);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, 0);
  endtask

  task automatic wr(input logic [5:0] rob, input logic [5:0] t1, input logic [63:0] v1,
                    input logic [5:0] t2, input logic [63:0] v2, input bit rdy);
    step(1, rob, t1, {1'b1, v1}, t2, {1'b0, v2}, 10'(rob * 3), 0, 0, rdy, 0);
  endtask

  task automatic do_reset();
    mon_en = 0;
    writeEn_i = 0; issueReady_i = 0; flush_i = 0; cdbTag_i = 0;
    reset_i = 0;
    #1;
    chk("rst_count", 64'(count_o), 0);
    chk("rst_valid", 64'(issueValid_o), 0);
    chk("rst_stall", 64'(stall_o), 0);
    chk("rst_tag", 64'(issueTag_o), 0);
    chk("rst_val1", issueVal1_o, 0);
    chk("rst_val2", issueVal2_o, 0);
    chk("rst_cmd", 64'(issueCmd_o), 0);
    mq.delete();
    @(posedge clk_i);
    #2;
    reset_i = 1;
    st_q.delete();
    iss_q.delete();
    mon_en = 1;
  endtask

  always @(negedge clk_i) begin
    if (mon_en) begin
      if (st_q.size() == 0) begin
        chk("status_underflow", 1, 0);
      end else begin
        st_t st;
        st = st_q.pop_front();
        chk("valid", 64'(issueValid_o), 64'(st.valid));
        chk("count", 64'(count_o), 64'(st.count));
        chk("stall", 64'(stall_o), 64'(st.stall));
        if (st.valid) begin
          chk("sel_tag", 64'(issueTag_o), 64'(st.rob));
          chk("sel_val1", issueVal1_o, st.v1);
          chk("sel_val2", issueVal2_o, st.v2);
          chk("sel_cmd", 64'(issueCmd_o), 64'(st.cmd));
        end
      end
      if (issueValid_o && issueReady_i) begin
        if (iss_q.size() == 0) begin
          chk("issue_unexpected", 1, 0);
        end else begin
          ent_t e;
          e = iss_q.pop_front();
          chk("iss_tag", 64'(issueTag_o), 64'(e.rob));
          chk("iss_val1", issueVal1_o, e.v1);
          chk("iss_val2", issueVal2_o, e.v2);
          chk("iss_cmd", 64'(issueCmd_o), 64'(e.cmd));
        end
      end
    end
  end

  initial begin
    reset_i = 1;
    writeEn_i = 0; robTag_i = 0; tag1_i = 0; tag2_i = 0; val1_i = 0; val2_i = 0;
    commands_i = 0; flush_i = 0; cdbTag_i = 0; cdbVal_i = 0; issueReady_i = 0;
    #1;
    do_reset();

    // three ready ops held back, then reset mid-stream
    wr(1, 0, 64'h11, 0, 64'h22, 0);
    wr(2, 0, 64'h33, 0, 64'h44, 0);
    wr(3, 0, 64'h55, 0, 64'h66, 0);
    idle(0);
    do_reset();

    wr(5, 0, 10, 0, 7, 0);
    idle(1);
    idle(0);

    wr(6, 3, 0, 0, 1, 0);
    wr(7, 0, 2, 0, 3, 0);
    idle(0);
    step(0, 0, 0, 0, 0, 0, 0, 3, 65'd99, 1, 0);
    idle(1);
    idle(0);

    for (int i = 0; i < 4; i++) wr(6'(10 + i), 0, 64'(i), 9, 0, 0);
    wr(14, 0, 1, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 9, 65'h1_0000_0000_0000_00AB, 0, 0);
    for (int i = 0; i < 4; i++) idle(1);
    idle(0);

    step(1, 20, 4, 0, 0, 5, 10'h3A, 4, 65'h1234, 0, 0);
    idle(1);
    idle(0);

    for (int i = 0; i < 4; i++) wr(6'(30 + i), 0, 64'(i), 0, 0, 0);
    step(1, 40, 0, 1, 0, 1, 1, 0, 0, 1, 1);
    idle(0);

    for (int n = 0; n < 1500; n++) begin
      logic [5:0] t1, t2, ct;
      t1 = $urandom_range(0, 1) ? 6'd0 : 6'($urandom_range(1, 7));
      t2 = $urandom_range(0, 1) ? 6'd0 : 6'($urandom_range(1, 7));
      ct = $urandom_range(0, 1) ? 6'd0 : 6'($urandom_range(1, 7));
      if ($urandom_range(0, 299) == 0) do_reset();
      step($urandom_range(0, 9) < 6, 6'($urandom), t1, {1'($urandom), $urandom, $urandom},
           t2, {1'($urandom), $urandom, $urandom}, 10'($urandom), ct,
           {1'($urandom), $urandom, $urandom}, $urandom_range(0, 3) != 0,
           $urandom_range(0, 39) == 0);
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    idle(0);
    chk("iss_q_drained", 64'(iss_q.size()), 0);
    chk("st_q_drained", 64'(st_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
